// File: rtl/blob_seq_tx.sv
// Threshold gray pixels into a framed 1-bit stream for the blob-labelling pipeline,
// then hold a drain gap and collect the pipeline's blob count (or time out).
module blob_seq_tx #(
  parameter int IMG_ROW     = 600,
  parameter int IMG_COL     = 800,
  parameter int GRAY_W      = 8,
  parameter int THRESH      = 128,
  parameter int GAP_CYC     = 200,
  parameter int RES_TIMEOUT = 300000,
  parameter int COUNT_W     = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_pix_valid,
  input  logic               i_pix_sof,
  input  logic [GRAY_W-1:0]  i_pix_gray,
  output logic               o_valid,
  output logic               o_seq,
  input  logic               i_blob_valid,
  input  logic [COUNT_W-1:0] i_blob_count,
  output logic [COUNT_W-1:0] o_count,
  output logic               o_count_valid,
  output logic               o_busy,
  output logic               o_frame_err
);

  localparam int ROW_W = (IMG_ROW > 1) ? $clog2(IMG_ROW) : 1;
  localparam int COL_W = (IMG_COL > 1) ? $clog2(IMG_COL) : 1;
  localparam int GAP_W = $clog2(GAP_CYC + 1);
  localparam int TMO_W = $clog2(RES_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_STREAM   = 2'd1,
    S_GAP      = 2'd2,
    S_WAIT_RES = 2'd3
  } state_t;

  state_t             state_q;
  logic [ROW_W-1:0]   row_q;
  logic [COL_W-1:0]   col_q;
  logic [GAP_W-1:0]   gap_q;
  logic [TMO_W-1:0]   tmo_q;
  logic               valid_q;
  logic               seq_q;
  logic [COUNT_W-1:0] count_q;
  logic               count_valid_q;
  logic               frame_err_q;

  logic               fg_s;
  logic               accept_s;
  logic               mid_sof_s;
  logic               last_col_s;
  logic               last_pix_s;
  logic [ROW_W-1:0]   cur_row_s;
  logic [COL_W-1:0]   cur_col_s;
  logic [ROW_W-1:0]   row_d;
  logic [COL_W-1:0]   col_d;

  assign fg_s = (i_pix_gray >= GRAY_W'(THRESH));

  // Position of the pixel being accepted (sof forces 0,0) and the position that follows it.
  always_comb begin
    accept_s  = 1'b0;
    mid_sof_s = 1'b0;
    if (state_q == S_IDLE) begin
      accept_s = i_pix_valid && i_pix_sof;
    end else if (state_q == S_STREAM) begin
      accept_s  = i_pix_valid;
      mid_sof_s = i_pix_valid && i_pix_sof && ((row_q != '0) || (col_q != '0));
    end else begin
      accept_s = 1'b0;
    end

    if (i_pix_sof) begin
      cur_row_s = '0;
      cur_col_s = '0;
    end else begin
      cur_row_s = row_q;
      cur_col_s = col_q;
    end

    last_col_s = (cur_col_s == COL_W'(IMG_COL - 1));
    last_pix_s = last_col_s && (cur_row_s == ROW_W'(IMG_ROW - 1));

    if (last_col_s) begin
      col_d = '0;
      row_d = cur_row_s + ROW_W'(1);
    end else begin
      col_d = cur_col_s + COL_W'(1);
      row_d = cur_row_s;
    end
  end

  // Frame FSM with registered stream, count and error outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= S_IDLE;
      row_q         <= '0;
      col_q         <= '0;
      gap_q         <= '0;
      tmo_q         <= '0;
      valid_q       <= 1'b0;
      seq_q         <= 1'b0;
      count_q       <= '0;
      count_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      valid_q       <= 1'b0;
      seq_q         <= 1'b0;
      count_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;

      case (state_q)
        S_IDLE, S_STREAM: begin
          if (accept_s) begin
            valid_q     <= 1'b1;
            seq_q       <= fg_s;
            frame_err_q <= mid_sof_s;
            if (last_pix_s) begin
              state_q <= S_GAP;
              row_q   <= '0;
              col_q   <= '0;
              gap_q   <= '0;
            end else begin
              state_q <= S_STREAM;
              row_q   <= row_d;
              col_q   <= col_d;
            end
          end else begin
            state_q <= state_q;
          end
        end

        S_GAP: begin
          if (gap_q == GAP_W'(GAP_CYC - 1)) begin
            state_q <= S_WAIT_RES;
            gap_q   <= '0;
            tmo_q   <= '0;
          end else begin
            gap_q <= gap_q + GAP_W'(1);
          end
        end

        // A result arriving on the final timeout cycle still wins over the timeout.
        S_WAIT_RES: begin
          if (i_blob_valid) begin
            count_q       <= i_blob_count;
            count_valid_q <= 1'b1;
            tmo_q         <= '0;
            state_q       <= S_IDLE;
          end else if (tmo_q == TMO_W'(RES_TIMEOUT - 1)) begin
            frame_err_q <= 1'b1;
            tmo_q       <= '0;
            state_q     <= S_IDLE;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end

        default: begin
          state_q <= S_IDLE;
          row_q   <= '0;
          col_q   <= '0;
          gap_q   <= '0;
          tmo_q   <= '0;
        end
      endcase
    end
  end

  assign o_valid       = valid_q;
  assign o_seq         = seq_q;
  assign o_count       = count_q;
  assign o_count_valid = count_valid_q;
  assign o_frame_err   = frame_err_q;
  assign o_busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_blob_seq_tx.sv
// Directed bench for blob_seq_tx on a 4x5 image: table-driven frame, then multi-cycle corner cases.
module tb_blob_seq_tx;

  localparam int IMG_ROW     = 4;
  localparam int IMG_COL     = 5;
  localparam int GRAY_W      = 8;
  localparam int THRESH      = 128;
  localparam int GAP_CYC     = 3;
  localparam int RES_TIMEOUT = 20;
  localparam int COUNT_W     = 8;

  logic               i_clk = 1'b0;
  logic               i_rst;
  logic               i_pix_valid;
  logic               i_pix_sof;
  logic [GRAY_W-1:0]  i_pix_gray;
  logic               o_valid;
  logic               o_seq;
  logic               i_blob_valid;
  logic [COUNT_W-1:0] i_blob_count;
  logic [COUNT_W-1:0] o_count;
  logic               o_count_valid;
  logic               o_busy;
  logic               o_frame_err;

  blob_seq_tx #(
    .IMG_ROW(IMG_ROW), .IMG_COL(IMG_COL), .GRAY_W(GRAY_W), .THRESH(THRESH),
    .GAP_CYC(GAP_CYC), .RES_TIMEOUT(RES_TIMEOUT), .COUNT_W(COUNT_W)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_pix_valid(i_pix_valid), .i_pix_sof(i_pix_sof), .i_pix_gray(i_pix_gray),
    .o_valid(o_valid), .o_seq(o_seq),
    .i_blob_valid(i_blob_valid), .i_blob_count(i_blob_count),
    .o_count(o_count), .o_count_valid(o_count_valid),
    .o_busy(o_busy), .o_frame_err(o_frame_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic       pv;
    logic       sof;
    logic [7:0] gray;
    logic       bv;
    logic [7:0] bc;
    logic       e_valid;
    logic       e_seq;
    logic       e_busy;
    logic       e_cv;
    logic       e_err;
    logic [7:0] e_count;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   err_cnt = 0;
  bit   got_q[$];
  bit   exp_q[$];
  vec_t vecs[26];

  function automatic vec_t mk(input logic pv, input logic sof, input logic [7:0] gray,
                              input logic bv, input logic [7:0] bc, input logic ev,
                              input logic es, input logic eb, input logic ecv,
                              input logic eerr, input logic [7:0] ecnt);
    vec_t v;
    v.pv = pv; v.sof = sof; v.gray = gray; v.bv = bv; v.bc = bc;
    v.e_valid = ev; v.e_seq = es; v.e_busy = eb; v.e_cv = ecv; v.e_err = eerr; v.e_count = ecnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock: inputs were set beforehand; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge i_clk);
    #1;
    if (o_valid) got_q.push_back(o_seq);
    else chk("seq_when_idle", {31'd0, o_seq}, 32'd0);
    if (o_frame_err) err_cnt++;
  endtask

  task automatic cmp_bits(input string name, input int exp_n);
    int mism;
    mism = 0;
    chk({name, "_nbits"}, got_q.size(), exp_n);
    chk({name, "_nexp"}, exp_q.size(), exp_n);
    for (int i = 0; i < exp_n && i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] != exp_q[i]) mism++;
    chk({name, "_bits"}, mism, 0);
  endtask

  task automatic set_pix(input logic pv, input logic sof, input logic [7:0] gray);
    i_pix_valid = pv;
    i_pix_sof   = sof;
    i_pix_gray  = gray;
  endtask

  task automatic drive_pix(input logic sof, input logic [7:0] gray);
    set_pix(1'b1, sof, gray);
    exp_q.push_back(gray >= 8'd128);
    step();
  endtask

  initial begin
    int n;
    logic [7:0] g;

    i_rst = 1'b1;
    set_pix(1'b1, 1'b1, 8'd200);
    i_blob_valid = 1'b1;
    i_blob_count = 8'd55;
    step();
    step();
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_seq", o_seq, 1'b0);
    chk("rst_count", o_count, 8'd0);
    chk("rst_cv", o_count_valid, 1'b0);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_err", o_frame_err, 1'b0);
    i_rst = 1'b0;
    set_pix(1'b0, 1'b0, 8'd0);
    i_blob_valid = 1'b0;
    i_blob_count = 8'd0;

    // Scenario 1+2: 20 pixels alternating 127/128, drops during GAP, result 7, ignored result in IDLE.
    for (int i = 0; i < 20; i++)
      vecs[i] = mk(1'b1, i == 0, (i % 2) ? 8'd128 : 8'd127, 1'b0, 8'd0,
                   1'b1, i % 2, 1'b1, 1'b0, 1'b0, 8'd0);
    vecs[20] = mk(1'b1, 1'b1, 8'd200, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    vecs[21] = mk(1'b0, 1'b0, 8'd0,   1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    vecs[22] = mk(1'b1, 1'b1, 8'd200, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    vecs[23] = mk(1'b0, 1'b0, 8'd0,   1'b1, 8'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd7);
    vecs[24] = mk(1'b0, 1'b0, 8'd0,   1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd7);
    vecs[25] = mk(1'b0, 1'b0, 8'd0,   1'b1, 8'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd7);

    for (int i = 0; i < 26; i++) begin
      set_pix(vecs[i].pv, vecs[i].sof, vecs[i].gray);
      i_blob_valid = vecs[i].bv;
      i_blob_count = vecs[i].bc;
      step();
      chk($sformatf("v%0d_valid", i), o_valid, vecs[i].e_valid);
      chk($sformatf("v%0d_seq", i), o_seq, vecs[i].e_seq);
      chk($sformatf("v%0d_busy", i), o_busy, vecs[i].e_busy);
      chk($sformatf("v%0d_cv", i), o_count_valid, vecs[i].e_cv);
      chk($sformatf("v%0d_err", i), o_frame_err, vecs[i].e_err);
      chk($sformatf("v%0d_count", i), o_count, vecs[i].e_count);
    end
    i_blob_valid = 1'b0;
    set_pix(1'b0, 1'b0, 8'd0);
    step();

    // Scenario 3: pixels every other cycle; result held early must only land in WAIT_RES.
    got_q.delete(); exp_q.delete();
    for (int k = 0; k < 20; k++) begin
      g = 8'(k * 37 + 11);
      drive_pix(k == 0, g);
      set_pix(1'b0, 1'b0, g);
      step();
    end
    chk("s3_busy_gap", o_busy, 1'b1);
    cmp_bits("s3", 20);
    i_blob_valid = 1'b1;
    i_blob_count = 8'd3;
    n = 0;
    while (!o_count_valid && n < 10) begin
      step();
      n++;
    end
    chk("s3_res_cycles", n, 3);
    chk("s3_count", o_count, 8'd3);
    i_blob_valid = 1'b0;
    step();
    chk("s3_idle", o_busy, 1'b0);
    chk("s3_cv_pulse", o_count_valid, 1'b0);

    // Scenario 4: sof again on the 9th pixel restarts the frame.
    got_q.delete(); exp_q.delete();
    err_cnt = 0;
    for (int k = 0; k < 28; k++) begin
      drive_pix(k == 0 || k == 8, 8'(k * 53 + 7));
      if (k == 8) chk("s4_err_pulse", o_frame_err, 1'b1);
      if (k == 9) chk("s4_err_clear", o_frame_err, 1'b0);
      if (k == 26) chk("s4_busy_stream", o_busy, 1'b1);
    end
    chk("s4_busy_gap", o_busy, 1'b1);
    chk("s4_err_cnt", err_cnt, 1);
    cmp_bits("s4", 28);

    // Scenario 5: no result; pixels with sof offered throughout GAP and WAIT_RES.
    set_pix(1'b1, 1'b1, 8'd255);
    n = 0;
    while (!o_frame_err && n < 40) begin
      step();
      n++;
    end
    set_pix(1'b0, 1'b0, 8'd0);
    chk("s5_timeout_cycles", n, GAP_CYC + RES_TIMEOUT);
    chk("s5_count_kept", o_count, 8'd3);
    chk("s5_cv", o_count_valid, 1'b0);
    chk("s5_busy", o_busy, 1'b0);
    chk("s5_no_bits", got_q.size(), 28);
    step();
    chk("s5_err_pulse", o_frame_err, 1'b0);
    chk("s5_idle", o_busy, 1'b0);

    // Scenario 6: reset at pixel 11 aborts the frame; the next frame is complete.
    for (int k = 0; k < 11; k++) begin
      set_pix(1'b1, k == 0, 8'(k * 29));
      step();
    end
    chk("s6_busy_pre", o_busy, 1'b1);
    i_rst = 1'b1;
    set_pix(1'b1, 1'b0, 8'd255);
    step();
    chk("s6_valid", o_valid, 1'b0);
    chk("s6_seq", o_seq, 1'b0);
    chk("s6_count", o_count, 8'd0);
    chk("s6_cv", o_count_valid, 1'b0);
    chk("s6_busy", o_busy, 1'b0);
    chk("s6_err", o_frame_err, 1'b0);
    i_rst = 1'b0;
    set_pix(1'b0, 1'b0, 8'd0);
    step();
    chk("s6_idle", o_busy, 1'b0);
    got_q.delete(); exp_q.delete();
    for (int k = 0; k < 20; k++) drive_pix(k == 0, 8'(k * 61 + 3));
    set_pix(1'b0, 1'b0, 8'd0);
    chk("s6_busy_gap", o_busy, 1'b1);
    cmp_bits("s6", 20);
    i_blob_valid = 1'b1;
    i_blob_count = 8'd42;
    n = 0;
    while (!o_count_valid && n < 10) begin
      step();
      n++;
    end
    chk("s6_res_cycles", n, GAP_CYC + 1);
    chk("s6_count_new", o_count, 8'd42);
    i_blob_valid = 1'b0;
    step();
    chk("s6_end_idle", o_busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
